// File: rtl/bp_fe_bp_gshare_ghr_if.sv
// Read/update/restore bundle between the front end and the gshare predictor.
// The predictor takes the slave modport; fetch and resolution logic drive the master side.
interface bp_fe_bp_gshare_ghr_if #(
   parameter int bht_idx_width_p = 9,
   parameter int ghist_width_p   = 8
);
   logic                       ready_o;
   logic                       r_v_i;
   logic [bht_idx_width_p-1:0] idx_r_i;
   logic                       predict_v_o;
   logic                       predict_o;
   logic [bht_idx_width_p-1:0] predict_idx_o;
   logic [ghist_width_p-1:0]   predict_ghist_o;
   logic                       w_v_i;
   logic [bht_idx_width_p-1:0] idx_w_i;
   logic                       taken_i;
   logic                       restore_v_i;
   logic [ghist_width_p-1:0]   ghist_restore_i;
   logic [31:0]                perf_pred_o;
   logic [31:0]                perf_miss_o;

   modport slave (
      output ready_o, predict_v_o, predict_o, predict_idx_o, predict_ghist_o,
             perf_pred_o, perf_miss_o,
      input  r_v_i, idx_r_i, w_v_i, idx_w_i, taken_i, restore_v_i, ghist_restore_i
   );

   modport master (
      input  ready_o, predict_v_o, predict_o, predict_idx_o, predict_ghist_o,
             perf_pred_o, perf_miss_o,
      output r_v_i, idx_r_i, w_v_i, idx_w_i, taken_i, restore_v_i, ghist_restore_i
   );
endinterface

// File: rtl/bp_fe_bp_gshare_ghr.sv
// Gshare direction predictor: GHR-hashed flop BHT, 1-cycle registered prediction,
// speculative history with restore, post-reset init sweep. BP_GSHARE_PERF_EN adds perf counters.
module bp_fe_bp_gshare_ghr #(
   parameter int bht_idx_width_p   = 9,
   parameter int bp_cnt_sat_bits_p = 2,
   parameter int ghist_width_p     = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   bp_fe_bp_gshare_ghr_if.slave     bp_if
);

   localparam int entries_lp = 1 << bht_idx_width_p;
   localparam logic [bp_cnt_sat_bits_p-1:0] cnt_max_lp = '1;
   localparam logic [bp_cnt_sat_bits_p-1:0] cnt_wnt_lp =
      bp_cnt_sat_bits_p'((1 << (bp_cnt_sat_bits_p - 1)) - 1);

   typedef enum logic {e_init, e_ready} state_e;

   typedef struct packed {
      logic                       taken;
      logic [bht_idx_width_p-1:0] idx;
      logic [ghist_width_p-1:0]   ghist;
   } pred_s;

   state_e                     state_q;
   logic [bht_idx_width_p-1:0] init_ptr_q;
   logic                       ready_q;

   logic [bp_cnt_sat_bits_p-1:0] bht_q [entries_lp];

   logic                     pv_q, pv_d;
   pred_s                    pred_q, pred_d;
   logic [ghist_width_p-1:0] ghr_q, ghr_d, ghr_shift;

   logic                         accept_r, accept_w, accept_rs;
   logic [bht_idx_width_p-1:0]   hash;
   logic [bp_cnt_sat_bits_p-1:0] cnt_old, cnt_upd, rd_cnt;
   logic                         wr_en;
   logic [bht_idx_width_p-1:0]   wr_idx;
   logic [bp_cnt_sat_bits_p-1:0] wr_data;

   // ready_o trails the INIT->READY transition by one edge, so it only rises
   // once every entry, including the last, has been written.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q    <= e_init;
         init_ptr_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         ready_q <= (state_q == e_ready);
         if (state_q == e_init) begin
            init_ptr_q <= init_ptr_q + bht_idx_width_p'(1);
            if (&init_ptr_q)
               state_q <= e_ready;
         end
      end
   end

   always_comb begin
      accept_r  = ready_q & bp_if.r_v_i;
      accept_w  = ready_q & bp_if.w_v_i;
      accept_rs = ready_q & bp_if.restore_v_i;
      hash      = bp_if.idx_r_i ^ bht_idx_width_p'(ghr_q);

      cnt_old = bht_q[bp_if.idx_w_i];
      cnt_upd = cnt_old;
      if (bp_if.taken_i && (cnt_old != cnt_max_lp))
         cnt_upd = cnt_old + bp_cnt_sat_bits_p'(1);
      else if (!bp_if.taken_i && (cnt_old != '0))
         cnt_upd = cnt_old - bp_cnt_sat_bits_p'(1);

      // Write-first bypass when the read hits the entry being updated.
      rd_cnt = (accept_w && (bp_if.idx_w_i == hash)) ? cnt_upd : bht_q[hash];

      wr_en   = reset_i & ((state_q == e_init) | accept_w);
      wr_idx  = (state_q == e_init) ? init_ptr_q : bp_if.idx_w_i;
      wr_data = (state_q == e_init) ? cnt_wnt_lp : cnt_upd;
   end

   always_ff @(posedge clk_i) begin
      if (wr_en)
         bht_q[wr_idx] <= wr_data;
   end

   if (ghist_width_p == 1) begin : g_shift1
      assign ghr_shift = pred_q.taken;
   end else begin : g_shiftn
      assign ghr_shift = {ghr_q[ghist_width_p-2:0], pred_q.taken};
   end

   always_comb begin
      pv_d   = accept_r;
      pred_d = pred_q;
      if (accept_r) begin
         pred_d.taken = rd_cnt[bp_cnt_sat_bits_p-1];
         pred_d.idx   = hash;
         pred_d.ghist = ghr_q;
      end
      // Restore beats the speculative shift of a prediction leaving the pipe.
      if (accept_rs)
         ghr_d = bp_if.ghist_restore_i;
      else if (pv_q)
         ghr_d = ghr_shift;
      else
         ghr_d = ghr_q;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         pv_q   <= 1'b0;
         pred_q <= '0;
         ghr_q  <= '0;
      end else begin
         pv_q   <= pv_d;
         pred_q <= pred_d;
         ghr_q  <= ghr_d;
      end
   end

   assign bp_if.ready_o         = ready_q;
   assign bp_if.predict_v_o     = pv_q;
   assign bp_if.predict_o       = pred_q.taken;
   assign bp_if.predict_idx_o   = pred_q.idx;
   assign bp_if.predict_ghist_o = pred_q.ghist;

`ifdef BP_GSHARE_PERF_EN
   logic [31:0] perf_pred_q, perf_pred_d;
   logic [31:0] perf_miss_q, perf_miss_d;
   logic        miss;

   always_comb begin
      miss        = accept_w & (cnt_old[bp_cnt_sat_bits_p-1] != bp_if.taken_i);
      perf_pred_d = (pv_q && !(&perf_pred_q)) ? perf_pred_q + 32'd1 : perf_pred_q;
      perf_miss_d = (miss && !(&perf_miss_q)) ? perf_miss_q + 32'd1 : perf_miss_q;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         perf_pred_q <= '0;
         perf_miss_q <= '0;
      end else begin
         perf_pred_q <= perf_pred_d;
         perf_miss_q <= perf_miss_d;
      end
   end

   assign bp_if.perf_pred_o = perf_pred_q;
   assign bp_if.perf_miss_o = perf_miss_q;
`else
   assign bp_if.perf_pred_o = '0;
   assign bp_if.perf_miss_o = '0;
`endif

endmodule
